// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/inc/dec buttons edit an hour/min/sec copy with blinking field and commit pulse.
// Define TIME_SET_AUTO_REPEAT_EN to enable auto-repeat of held inc/dec buttons.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLINK_CYCLES    = 12500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       set_active,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic [5:0] blank_mask
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t          state;
  logic [BL_W-1:0] blink_cnt;
  logic            phase;

  // Button index: 0 mode, 1 inc, 2 dec
  logic [2:0] raw_btn, sync_a, sync_b, db_level, db_level_q, press;
  logic [1:0] rep;
  logic       mode_ev, inc_ev, dec_ev;

  assign raw_btn = {btn_dec, btn_inc, btn_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a     <= 3'b000;
      sync_b     <= 3'b000;
      db_level_q <= 3'b000;
    end else begin
      sync_a     <= raw_btn;
      sync_b     <= sync_a;
      db_level_q <= db_level;
    end
  end

  // Level follows the synchronized input only after an unbroken run of differing samples
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_b[g] == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_b[g];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db_level[g] = level;
  end

  assign press = db_level & ~db_level_q;

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RP_W    = $clog2(REP_MAX + 1);

  logic rep_clr;
  assign rep_clr = (state == RUN) || press[0] || (db_level[1] && db_level[2]);

  // armed selects the long initial delay versus the steady repeat interval
  for (genvar g = 0; g < 2; g++) begin : g_rep
    logic [RP_W-1:0] cnt;
    logic            armed;

    assign rep[g] = db_level[g+1] && !rep_clr &&
                    (cnt == (armed ? RP_W'(REPEAT_RATE) : RP_W'(REPEAT_DELAY)));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (!db_level[g+1] || rep_clr) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (rep[g]) begin
        cnt   <= RP_W'(1);
        armed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic unused_rep_cfg;
  assign rep            = 2'b00;
  assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  assign mode_ev = press[0];
  assign inc_ev  = press[1] | rep[0];
  assign dec_ev  = press[2] | rep[1];

  // Out-of-range values (e.g. hour 27) wrap to 0 on increment
  function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
    if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [5:0] field_mask(input state_t s);
    case (s)
      SET_HOUR: return 6'b110000;
      SET_MIN:  return 6'b001100;
      SET_SEC:  return 6'b000011;
      default:  return 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      set_active <= 1'b0;
      set_hour   <= 5'd0;
      set_min    <= 6'd0;
      set_sec    <= 6'd0;
      load       <= 1'b0;
      blank_mask <= 6'd0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (mode_ev) begin
            state      <= SET_HOUR;
            set_active <= 1'b1;
            set_hour   <= cur_hour;
            set_min    <= cur_min;
            set_sec    <= cur_sec;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blank_mask <= 6'd0;
          end
        end
        default: begin
          if (mode_ev) begin
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blank_mask <= 6'd0;
            case (state)
              SET_HOUR: state <= SET_MIN;
              SET_MIN:  state <= SET_SEC;
              default: begin
                state      <= RUN;
                set_active <= 1'b0;
                load       <= 1'b1;
              end
            endcase
          end else if (inc_ev ^ dec_ev) begin
            // Restart the blink so the edited digits show immediately
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blank_mask <= 6'd0;
            case (state)
              SET_HOUR: set_hour <= hr_step(set_hour, inc_ev);
              SET_MIN:  set_min  <= ms_step(set_min, inc_ev);
              default:  set_sec  <= ms_step(set_sec, inc_ev);
            endcase
          end else if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt  <= '0;
            phase      <= ~phase;
            blank_mask <= phase ? 6'd0 : field_mask(state);
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven time-setting controller for the digital clock; it is the writer side of the hour/min/sec bus that the display scanner reads.
- Debounces three raw push-buttons and steps through hour, minute and second edit fields.
- Holds an edit copy of the time, outputs a per-digit blank mask so the display blinks the field being edited, and issues a one-cycle load pulse to commit the new time to the time counter.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples needed to accept a level change (1 ms at 50 MHz); minimum 1.
- BLINK_CYCLES, 12500000: clk cycles per blink half-period (0.25 s at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000: hold time before auto-repeat starts; used only with AUTO_REPEAT_EN.
- REPEAT_RATE, 5000000: cycles between repeat events; used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- btn_mode, input, 1: raw mode button, active-high, asynchronous to clk.
- btn_inc, input, 1: raw increment button, active-high, asynchronous to clk.
- btn_dec, input, 1: raw decrement button, active-high, asynchronous to clk.
- cur_hour, input, 5: running hour, 0-23.
- cur_min, input, 6: running minute, 0-59.
- cur_sec, input, 6: running second, 0-59.
- set_active, output, 1: high in any edit state; the time counter holds its count while this is high.
- set_hour, output, 5: edited hour.
- set_min, output, 6: edited minute.
- set_sec, output, 6: edited second.
- load, output, 1: one-cycle commit pulse; set_* are valid in the same cycle.
- blank_mask, output, 6: bit i = 1 blanks digit i. Order: bit0 sec ones, bit1 sec tens, bit2 min ones, bit3 min tens, bit4 hour ones, bit5 hour tens.

Behaviour:
- Reset: clk and rst only; rst is asynchronous, active-high. Reset values:
  - set_active=0, load=0, blank_mask=0, set_hour/min/sec=0.
  - FSM=RUN; blink phase=0; all synchronizers, debounce counters and debounced levels cleared to 0.
- Input conditioning, per button:
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any sample equal to the current level clears the counter.
  - A press event is a 1-cycle pulse on the debounced rising edge. Release generates no event.
  - Latency: raw high held from edge 0 gives the press event at edge 2+DEBOUNCE_CYCLES, ±1 cycle of sampling uncertainty.
  - Shorter glitches produce no event.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - RUN + mode: go to SET_HOUR. Copy cur_hour/min/sec into set_* in the same edge; set_active=1 from the next cycle.
  - SET_HOUR + mode: go to SET_MIN.
  - SET_MIN + mode: go to SET_SEC.
  - SET_SEC + mode: go to RUN. load=1 for exactly that one cycle with final set_* values; set_active=0 in the same cycle.
  - RUN ignores inc/dec.
- Field arithmetic, applied to the active field only:
  - inc: hour 23→0, otherwise +1; min/sec 59→0, otherwise +1.
  - dec: hour 0→23, otherwise −1; min/sec 0→59, otherwise −1.
  - The update is registered and visible the cycle after the event.
- Simultaneous events:
  - inc and dec in the same cycle: no change.
  - mode with inc/dec in the same cycle: mode wins and inc/dec are discarded.
- set_* hold their values in RUN; they are not tracked to cur_*.
- Blink:
  - A free-running counter toggles the phase every BLINK_CYCLES cycles while set_active=1.
  - Counter and phase are cleared on entering SET_HOUR and on every field transition, so each field starts visible.
  - blank_mask = phase ? active-field bits : 0. Hour → 6'b110000, min → 6'b001100, sec → 6'b000011.
  - blank_mask = 0 in RUN.
  - An inc/dec event clears the phase to 0 and restarts the counter, so the digit is visible right after an edit.
- Reset mid-edit: returns to RUN, no load pulse, edits lost.
- Out-of-range cur_* on entry (e.g. hour 27): the value is copied as-is; the first inc wraps it to 0; the first dec gives value−1 unless the value is 0.

Optional Feature:
- TIME_SET_AUTO_REPEAT_EN defined:
  - While the debounced inc (or dec) stays high in an edit state, an extra event is generated REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles.
  - The repeat timer clears on release, on a mode event, and while both inc and dec are held.
- Undefined: repeat logic is absent; holding a button yields exactly one event.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, REPEAT_DELAY=20, REPEAT_RATE=5.
- Bounce: btn_inc high 3 cycles, low 1 cycle, repeated 5 times in SET_MIN at min=10 → min stays 10. Then held high 10 cycles → min=11 exactly once.
- Full edit from cur=23:59:58:
  - mode → set_active=1.
  - inc at hour → 0.
  - mode, then dec at min → 58.
  - mode, then inc ×3 at sec → 59, 0, 1.
  - mode → single-cycle load with set=00:58:01, then set_active=0.
- Blink: in SET_HOUR, no buttons for 32 cycles → blank_mask alternates 0/6'b110000 every 8 cycles starting visible. After mode it starts at 0, then 6'b001100.
- Simultaneous: inc and dec debounced-high on the same edge in SET_SEC at sec=30 → sec=30. mode and inc together in SET_HOUR → state SET_MIN, hour unchanged.
- Reset: rst asserted mid-SET_MIN → all outputs 0, no load. Reassert cur=05:06:07 and press mode → set_*=05:06:07.
- TIME_SET_AUTO_REPEAT_EN: hold inc 40 cycles after acceptance in SET_SEC at 0 → events at offsets 0, 20, 25, 30, 35, giving sec=5. Macro undefined → sec=1.
